// File: rtl/cam_pg_pkg.sv
// cam_pg_pkg: shared FSM states, pattern/format codes and bar colour table for cam_pattern_gen.
package cam_pg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBP,
        LINE,
        HBLK
    } state_e;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_SOLID = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_RAMP  = 2'd3;

    localparam logic FMT_RGB565 = 1'b0;
    localparam logic FMT_RGB444 = 1'b1;

    // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][15:0] BAR_RGB = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

endpackage

// File: rtl/cam_pg_pixel.sv
// cam_pg_pixel: combinational pixel-byte generator for one (x, y) position and byte half.
module cam_pg_pixel
    import cam_pg_pkg::*;
#(
    parameter int H_ACTIVE = 160
) (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic [1:0]  pattern_i,
    input  logic        fmt_i,
    input  logic        byte_sel_i,
    input  logic [15:0] solid_rgb_i,
    output logic [7:0]  data_o
);

    localparam logic [15:0] BAR_W = 16'((H_ACTIVE / 8) > 0 ? (H_ACTIVE / 8) : 1);

    logic [15:0] bar;
    logic [15:0] xy;
    logic [2:0]  idx;
    logic [15:0] rgb;

    always_comb begin
        bar    = x_i / BAR_W;
        idx    = (bar > 16'd7) ? 3'd7 : bar[2:0];
        xy     = x_i ^ y_i;
        rgb    = (pattern_i == PAT_SOLID) ? solid_rgb_i :
                 (pattern_i == PAT_CHECK) ? (xy[3] ? 16'h0000 : 16'hFFFF) :
                 (pattern_i == PAT_RAMP)  ? {x_i[4:0], x_i[5:0], x_i[4:0]} :
                                            BAR_RGB[idx];
        // RGB444 keeps the top nibble of each RGB565 component.
        data_o = (fmt_i == FMT_RGB444) ?
                     (byte_sel_i ? {rgb[10:7], rgb[4:1]} : {4'h0, rgb[15:12]}) :
                     (byte_sel_i ? rgb[7:0] : rgb[15:8]);
    end

endmodule

// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen: OV7670-style camera source with PCLK divider, frame FSM and test patterns.
// Optional CAM_PG_FRAME_CNT_EN adds frame_cnt and frame_done outputs.
module cam_pattern_gen
    import cam_pg_pkg::*;
#(
    parameter int H_ACTIVE   = 160,
    parameter int V_ACTIVE   = 120,
    parameter int H_BLANK    = 4,
    parameter int V_BLANK    = 4,
    parameter int VSYNC_ROWS = 2,
    parameter int PCLK_DIV   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern,
    input  logic        fmt,
    input  logic [15:0] solid_rgb,
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_px_data,
`ifdef CAM_PG_FRAME_CNT_EN
    output logic [15:0] frame_cnt,
    output logic        frame_done,
`endif
    output logic        busy
);

    localparam int ROW_SLOTS  = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_ROWS = V_BLANK + V_ACTIVE;
    localparam int CW = $clog2(ROW_SLOTS);
    localparam int RW = $clog2(FRAME_ROWS);
    localparam int DW = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(ROW_SLOTS - 1);
    localparam logic [CW-1:0] ACT_LAST = CW'(2 * H_ACTIVE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_ROWS - 1);
    localparam logic [RW-1:0] VS_LAST  = RW'(VSYNC_ROWS - 1);
    localparam logic [RW-1:0] VB_LAST  = RW'(V_BLANK - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic          pclk_q;
    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    pat_q, pat_d;
    logic          fmt_q, fmt_d;
    logic [15:0]   solid_q, solid_d;
    logic          vsync_q, href_q, busy_q;
    logic [7:0]    data_q;
    logic [7:0]    pix;
    logic          tick, slot, last_col, last_row, frame_start;

    assign tick = div_q == DIV_LAST;

    // Counters always describe the slot being driven, so outputs come from the next position.
    always_comb begin
        slot        = tick && pclk_q;
        last_col    = col_q == COL_LAST;
        last_row    = row_q == ROW_LAST;
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        pat_d       = pat_q;
        fmt_d       = fmt_q;
        solid_d     = solid_q;
        if (slot && state_q != IDLE) begin
            col_d = last_col ? '0 : col_q + 1'b1;
            row_d = !last_col ? row_q : last_row ? '0 : row_q + 1'b1;
        end
        if (slot) begin
            case (state_q)
                IDLE:    state_d = enable ? VSYNC : IDLE;
                VSYNC:   state_d = (last_col && row_q == VS_LAST) ? VBP : VSYNC;
                VBP:     state_d = (last_col && row_q == VB_LAST) ? LINE : VBP;
                LINE:    state_d = (col_q == ACT_LAST) ? HBLK : LINE;
                HBLK:    state_d = !last_col ? HBLK : !last_row ? LINE : enable ? VSYNC : IDLE;
                default: state_d = IDLE;
            endcase
        end
        frame_start = slot && state_d == VSYNC && state_q != VSYNC;
        if (frame_start) begin
            pat_d   = pattern;
            fmt_d   = fmt;
            solid_d = solid_rgb;
        end
    end

    cam_pg_pixel #(
        .H_ACTIVE(H_ACTIVE)
    ) u_pixel (
        .x_i        (16'(col_d >> 1)),
        .y_i        (16'(row_d) - 16'(V_BLANK)),
        .pattern_i  (pat_q),
        .fmt_i      (fmt_q),
        .byte_sel_i (col_d[0]),
        .solid_rgb_i(solid_q),
        .data_o     (pix)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= '0;
            pclk_q  <= 1'b0;
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            pat_q   <= PAT_BARS;
            fmt_q   <= FMT_RGB565;
            solid_q <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            div_q   <= tick ? '0 : div_q + 1'b1;
            pclk_q  <= tick ? !pclk_q : pclk_q;
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pat_q   <= pat_d;
            fmt_q   <= fmt_d;
            solid_q <= solid_d;
            if (slot) begin
                vsync_q <= state_d == VSYNC;
                href_q  <= state_d == LINE;
                data_q  <= (state_d == LINE) ? pix : 8'h00;
                busy_q  <= state_d != IDLE;
            end
        end
    end

    assign cam_pclk    = pclk_q;
    assign cam_vsync   = vsync_q;
    assign cam_href    = href_q;
    assign cam_px_data = data_q;
    assign busy        = busy_q;

`ifdef CAM_PG_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    logic        frame_done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_start ? frame_cnt_q + 1'b1 : frame_cnt_q;
            frame_done_q <= slot && state_q == HBLK && last_col && last_row;
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_cam_pattern_gen.sv
// tb_cam_pattern_gen: randomized bench comparing cam_pattern_gen against a slot-index frame model.
`timescale 1ns/1ps
module tb_cam_pattern_gen;

    localparam int HA = 16, VA = 4, HB = 4, VB = 4, VS = 2;
    localparam int ROW = 2 * HA + HB;
    localparam int FRAME = (VB + VA) * ROW;

    logic        clk = 1'b0, rst = 1'b0, enable = 1'b0, fmt = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic [15:0] solid_rgb = 16'h0000;
    logic        cam_pclk, cam_vsync, cam_href, busy;
    logic [7:0]  cam_px_data;
`ifdef CAM_PG_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic        frame_done;
`endif

    int checks = 0, failures = 0;

    cam_pattern_gen #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .V_BLANK(VB), .VSYNC_ROWS(VS), .PCLK_DIV(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pattern    (pattern),
        .fmt        (fmt),
        .solid_rgb  (solid_rgb),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_px_data(cam_px_data),
`ifdef CAM_PG_FRAME_CNT_EN
        .frame_cnt  (frame_cnt),
        .frame_done (frame_done),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    logic        s_rst = 1'b0, s_en = 1'b0, s_fmt = 1'b0;
    logic [1:0]  s_pat = 2'd0;
    logic [15:0] s_solid = 16'h0000;

    always @(posedge clk) begin
        s_rst   <= rst;
        s_en    <= enable;
        s_pat   <= pattern;
        s_fmt   <= fmt;
        s_solid <= solid_rgb;
    end

    function automatic logic [7:0] model_byte(input int x, input int y, input int pat,
                                              input bit f, input bit sel, input logic [15:0] solid);
        int r, g, b, bar;
        case (pat)
            0: begin
                bar = x / (HA / 8);
                if (bar > 7) bar = 7;
                r = ((bar / 2) % 2 == 0) ? 31 : 0;
                g = (bar < 4) ? 63 : 0;
                b = (bar % 2 == 0) ? 31 : 0;
            end
            1: begin
                r = int'(solid >> 11);
                g = int'((solid >> 5) & 16'h003F);
                b = int'(solid & 16'h001F);
            end
            2: begin
                r = (((x / 8) + (y / 8)) % 2 == 0) ? 31 : 0;
                g = (r != 0) ? 63 : 0;
                b = r;
            end
            default: begin
                r = x % 32;
                g = x % 64;
                b = x % 32;
            end
        endcase
        if (!f) return sel ? 8'((g % 8) * 32 + b) : 8'(r * 8 + g / 8);
        return sel ? 8'((g / 4) * 16 + b / 2) : 8'(r / 2);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    int          m_p = 0, m_frames = 0, m_pat = 0;
    bit          m_pclk = 0, m_act = 0, m_done = 0, m_start = 0, m_fmt = 0;
    logic [15:0] m_solid = 16'h0000;
    int          row, col;
    bit          e_vs, e_href;
    logic [7:0]  e_data;
    bit          cnt_en = 0;
    int          n_busy = 0, n_vs = 0, n_href = 0;
    logic [7:0]  cap[$];

    // Model: frame position is a flat slot index; every output follows from row/col arithmetic.
    initial forever begin
        @(negedge clk);
        m_done  = 0;
        m_start = 0;
        if (!rst || !s_rst) begin
            m_pclk = 0; m_act = 0; m_p = 0; m_frames = 0;
        end else begin
            if (m_pclk) begin
                if (m_act) begin
                    m_p++;
                    if (m_p == FRAME) begin
                        m_p = 0; m_done = 1; m_act = s_en; m_start = s_en;
                    end
                end else if (s_en) begin
                    m_act = 1; m_start = 1;
                end
                if (m_start) begin
                    m_pat = int'(s_pat); m_fmt = s_fmt; m_solid = s_solid;
                    m_frames = (m_frames + 1) % 65536;
                end
            end
            m_pclk = !m_pclk;
        end
        row    = m_p / ROW;
        col    = m_p % ROW;
        e_vs   = m_act && row < VS;
        e_href = m_act && row >= VB && col < 2 * HA;
        e_data = e_href ? model_byte(col / 2, row - VB, m_pat, m_fmt, col[0], m_solid) : 8'h00;
        checks++;
        if ({cam_pclk, cam_vsync, cam_href, cam_px_data, busy} !== {m_pclk, e_vs, e_href, e_data, m_act}) begin
            failures++;
            $display("FAIL outputs t=%0t got pclk=%b vs=%b href=%b data=%h busy=%b expected pclk=%b vs=%b href=%b data=%h busy=%b",
                     $time, cam_pclk, cam_vsync, cam_href, cam_px_data, busy, m_pclk, e_vs, e_href, e_data, m_act);
        end
`ifdef CAM_PG_FRAME_CNT_EN
        checks++;
        if ({frame_cnt, frame_done} !== {16'(m_frames), m_done}) begin
            failures++;
            $display("FAIL frame_status t=%0t got cnt=%0d done=%b expected cnt=%0d done=%b",
                     $time, frame_cnt, frame_done, m_frames, m_done);
        end
`endif
        if (cnt_en) begin
            n_busy += int'(busy);
            n_vs   += int'(cam_vsync);
            n_href += int'(cam_href);
            if (cam_href && !cam_pclk) cap.push_back(cam_px_data);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int lim);
        int k = 0;
        while (busy && k < lim) begin
            step(1);
            k++;
        end
        check("idle_reached", int'(busy), 0);
    endtask

    task automatic start_capture();
        cap.delete();
        n_busy = 0; n_vs = 0; n_href = 0;
        cnt_en = 1;
    endtask

    initial begin
        int bad, k;
        check("model_white_hi", int'(model_byte(0, 0, 0, 0, 0, 16'h0)), 8'hFF);
        check("model_yellow_lo", int'(model_byte(2, 0, 0, 0, 1, 16'h0)), 8'hE0);
        check("model_cyan_hi", int'(model_byte(4, 0, 0, 0, 0, 16'h0)), 8'h07);
        check("model_444_red_hi", int'(model_byte(0, 0, 1, 1, 0, 16'hF800)), 8'h0F);
        check("model_check_black", int'(model_byte(8, 0, 2, 0, 0, 16'h0)), 8'h00);

        step(5);
        rst = 1'b1;
        step(10);
        check("idle_busy", int'(busy), 0);
        check("idle_vsync", int'(cam_vsync), 0);

        // Bars frame, enable dropped early: the frame must still complete.
        start_capture();
        enable = 1'b1;
        step(20);
        enable = 1'b0;
        wait_idle(2000);
        step(10);
        cnt_en = 0;
        check("frame_busy_clks", n_busy, 2 * FRAME);
        check("vsync_clks", n_vs, 2 * VS * ROW);
        check("href_clks", n_href, 2 * VA * 2 * HA);
        check("active_bytes", cap.size(), VA * 2 * HA);
        check("post_vsync", int'(cam_vsync), 0);
        if (cap.size() == VA * 2 * HA) begin
            check("byte0", int'(cap[0]), 8'hFF);
            check("byte1", int'(cap[1]), 8'hFF);
            check("byte5", int'(cap[5]), 8'hE0);
            check("byte8", int'(cap[8]), 8'h07);
            check("byte9", int'(cap[9]), 8'hFF);
            check("byte30", int'(cap[30]), 8'h00);
            check("byte31", int'(cap[31]), 8'h00);
        end

        // Solid red in RGB444.
        pattern = 2'd1; solid_rgb = 16'hF800; fmt = 1'b1;
        start_capture();
        enable = 1'b1;
        step(30);
        enable = 1'b0;
        wait_idle(2000);
        cnt_en = 0;
        bad = 0;
        foreach (cap[i]) bad += int'(cap[i] != ((i % 2 == 0) ? 8'h0F : 8'h00));
        check("solid444_bytes", cap.size(), VA * 2 * HA);
        check("solid444_bad", bad, 0);

        // Pattern change mid-frame only takes effect on the following frame.
        pattern = 2'd0; fmt = 1'b0;
        enable = 1'b1;
        step(200);
        pattern = 2'd2;
        k = 0;
        while (!cam_vsync && k < 2000) begin
            step(1);
            k++;
        end
        check("next_frame_vsync", int'(cam_vsync), 1);
        enable = 1'b0;
        start_capture();
        wait_idle(2000);
        cnt_en = 0;
        bad = 0;
        foreach (cap[i]) bad += int'(cap[i] != ((((i / 2) % HA) < 8) ? 8'hFF : 8'h00));
        check("checker_bytes", cap.size(), VA * 2 * HA);
        check("checker_bad", bad, 0);
`ifdef CAM_PG_FRAME_CNT_EN
        check("frame_cnt_4", int'(frame_cnt), 4);
`endif

        for (int i = 0; i < 8; i++) begin
            pattern   = 2'($urandom_range(0, 3));
            fmt       = 1'($urandom_range(0, 1));
            solid_rgb = 16'($urandom);
            enable    = 1'($urandom_range(0, 1));
            step($urandom_range(50, 700));
        end
        enable = 1'b0;
        wait_idle(2000);

        // Reset in the middle of a line aborts at once.
        pattern = 2'd3;
        enable = 1'b1;
        k = 0;
        while (!cam_href && k < 2000) begin
            step(1);
            k++;
        end
        check("line_reached", int'(cam_href), 1);
        step(3);
        rst = 1'b0;
        #1;
        check("rst_outputs", int'({cam_pclk, cam_vsync, cam_href, cam_px_data, busy}), 0);
        step(3);
        enable = 1'b0;
        rst = 1'b1;
        step(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
